// File: rtl/ibex_bus_arbiter_if.sv
// ibex_bus_arbiter_if: core instr/data ports and shared host bus of the arbiter
interface ibex_bus_arbiter_if;
  logic        instr_req_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_addr_i;
  logic [31:0] instr_rdata_o;
  logic [6:0]  instr_rdata_intg_o;
  logic        instr_err_o;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [6:0]  data_wdata_intg_i;
  logic [31:0] data_rdata_o;
  logic [6:0]  data_rdata_intg_o;
  logic        data_err_o;
  logic        host_req_o;
  logic        host_gnt_i;
  logic        host_rvalid_i;
  logic        host_we_o;
  logic [3:0]  host_be_o;
  logic [31:0] host_addr_o;
  logic [31:0] host_wdata_o;
  logic [6:0]  host_wdata_intg_o;
  logic [31:0] host_rdata_i;
  logic [6:0]  host_rdata_intg_i;
  logic        host_err_i;
  logic        protocol_err_o;
  modport slave (
    input  instr_req_i, instr_addr_i, data_req_i, data_we_i, data_be_i, data_addr_i,
           data_wdata_i, data_wdata_intg_i, host_gnt_i, host_rvalid_i, host_rdata_i,
           host_rdata_intg_i, host_err_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_rdata_intg_o, instr_err_o,
           data_gnt_o, data_rvalid_o, data_rdata_o, data_rdata_intg_o, data_err_o,
           host_req_o, host_we_o, host_be_o, host_addr_o, host_wdata_o, host_wdata_intg_o,
           protocol_err_o
  );
  modport master (
    output instr_req_i, instr_addr_i, data_req_i, data_we_i, data_be_i, data_addr_i,
           data_wdata_i, data_wdata_intg_i, host_gnt_i, host_rvalid_i, host_rdata_i,
           host_rdata_intg_i, host_err_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_rdata_intg_o, instr_err_o,
           data_gnt_o, data_rvalid_o, data_rdata_o, data_rdata_intg_o, data_err_o,
           host_req_o, host_we_o, host_be_o, host_addr_o, host_wdata_o, host_wdata_intg_o,
           protocol_err_o
  );
endinterface

// File: rtl/ibex_bus_arbiter.sv
// ibex_bus_arbiter: round-robin arbiter of ibex instr/data ports onto one host bus
module ibex_bus_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          DataFirst      = 1'b1
) (
  input logic               clk_i,
  input logic               rst_i,
  ibex_bus_arbiter_if.slave bus
);
  localparam int unsigned PW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CW = $clog2(MaxOutstanding + 1);
  typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_e;
  state_e              state_q, state_d;
  logic                rr_data_q, sel_d, req, accept, pop, full, head, perr_q;
  logic [PW-1:0]       wptr_q, rptr_q;
  logic [CW-1:0]       cnt_q;
  logic [MaxOutstanding-1:0] src_q;
  function automatic logic [PW-1:0] incr(input logic [PW-1:0] p);
    return (p == PW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction
  assign full = cnt_q == CW'(MaxOutstanding);
  // HOLD_x keeps presenting the frozen selection until the host grants it
  always_comb begin
    state_d = state_q;
    sel_d   = 1'b0;
    req     = 1'b0;
    case (state_q)
      HOLD_I: begin
        req     = 1'b1;
        state_d = bus.host_gnt_i ? IDLE : HOLD_I;
      end
      HOLD_D: begin
        req     = 1'b1;
        sel_d   = 1'b1;
        state_d = bus.host_gnt_i ? IDLE : HOLD_D;
      end
      default: begin
        req     = ~full & (bus.instr_req_i | bus.data_req_i);
        sel_d   = bus.data_req_i & (~bus.instr_req_i | rr_data_q);
        state_d = (req & ~bus.host_gnt_i) ? (sel_d ? HOLD_D : HOLD_I) : IDLE;
      end
    endcase
  end
  assign bus.host_req_o        = req & ~rst_i;
  assign accept                = bus.host_req_o & bus.host_gnt_i;
  assign bus.instr_gnt_o       = accept & ~sel_d;
  assign bus.data_gnt_o        = accept & sel_d;
  assign bus.host_addr_o       = sel_d ? bus.data_addr_i : bus.instr_addr_i;
  assign bus.host_we_o         = sel_d & bus.data_we_i;
  assign bus.host_be_o         = sel_d ? bus.data_be_i : 4'hF;
  assign bus.host_wdata_o      = sel_d ? bus.data_wdata_i : 32'h0;
  assign bus.host_wdata_intg_o = sel_d ? bus.data_wdata_intg_i : 7'h0;
  // src_q holds the source of each outstanding transaction: 1 = data port
  assign pop                   = bus.host_rvalid_i & |cnt_q & ~rst_i;
  assign head                  = src_q[rptr_q];
  assign bus.instr_rvalid_o    = pop & ~head;
  assign bus.data_rvalid_o     = pop & head;
  assign bus.instr_rdata_o      = bus.host_rdata_i;
  assign bus.instr_rdata_intg_o = bus.host_rdata_intg_i;
  assign bus.instr_err_o        = bus.host_err_i;
  assign bus.data_rdata_o       = bus.host_rdata_i;
  assign bus.data_rdata_intg_o  = bus.host_rdata_intg_i;
  assign bus.data_err_o         = bus.host_err_i;
  assign bus.protocol_err_o     = perr_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rr_data_q <= DataFirst;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      perr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rr_data_q     <= ~sel_d;
        src_q[wptr_q] <= sel_d;
        wptr_q        <= incr(wptr_q);
      end
      if (pop) rptr_q <= incr(rptr_q);
      cnt_q <= cnt_q + CW'(accept) - CW'(pop);
      if (bus.host_rvalid_i & ~|cnt_q) perr_q <= 1'b1;
    end
  end
endmodule

// File: doc/ibex_bus_arbiter.md
IBEX_BUS_ARBITER -- requirements
Module: ibex_bus_arbiter
Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2, max host transactions granted but not yet responded (1..4).
REQ-002 SHALL have parameter DataFirst, default 1'b1; after reset, the round-robin pointer favours the data port when 1, the instr port when 0.
REQ-003 SHALL have port clk_i  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port instr_req_i  in  1  core instruction request.
REQ-006 SHALL have port instr_gnt_o  out  1  instruction grant.
REQ-007 SHALL have port instr_rvalid_o  out  1  instruction response valid.
REQ-008 SHALL have port instr_addr_i  in  32  instruction address.
REQ-009 SHALL have port instr_rdata_o  out  32  instruction read data.
REQ-010 SHALL have port instr_rdata_intg_o  out  7  instruction read-data integrity.
REQ-011 SHALL have port instr_err_o  out  1  instruction bus error.
REQ-012 SHALL have port data_req_i  in  1  core data request.
REQ-013 SHALL have port data_gnt_o  out  1  data grant.
REQ-014 SHALL have port data_rvalid_o  out  1  data response valid.
REQ-015 SHALL have port data_we_i  in  1  data write enable.
REQ-016 SHALL have port data_be_i  in  4  data byte enables.
REQ-017 SHALL have port data_addr_i  in  32  data address.
REQ-018 SHALL have port data_wdata_i  in  32  data write data.
REQ-019 SHALL have port data_wdata_intg_i  in  7  data write-data integrity.
REQ-020 SHALL have port data_rdata_o  out  32  data read data.
REQ-021 SHALL have port data_rdata_intg_o  out  7  data read-data integrity.
REQ-022 SHALL have port data_err_o  out  1  data bus error.
REQ-023 SHALL have port host_req_o  out  1  shared-bus request.
REQ-024 SHALL have port host_gnt_i  in  1  shared-bus grant.
REQ-025 SHALL have port host_rvalid_i  in  1  shared-bus response valid.
REQ-026 SHALL have port host_we_o  out  1  shared-bus write enable.
REQ-027 SHALL have port host_be_o  out  4  shared-bus byte enables.
REQ-028 SHALL have port host_addr_o  out  32  shared-bus address.
REQ-029 SHALL have port host_wdata_o  out  32  shared-bus write data.
REQ-030 SHALL have port host_wdata_intg_o  out  7  shared-bus write integrity.
REQ-031 SHALL have port host_rdata_i  in  32  shared-bus read data.
REQ-032 SHALL have port host_rdata_intg_i  in  7  shared-bus read integrity.
REQ-033 SHALL have port host_err_i  in  1  shared-bus error.
REQ-034 SHALL have port protocol_err_o  out  1  sticky flag: rvalid received with no outstanding transaction.
Function
REQ-035 SHALL run FSM IDLE/HOLD_I/HOLD_D; HOLD_x = request presented on host, not yet granted, selection frozen.
REQ-036 In IDLE with count<MaxOutstanding, SHALL select: single requester wins; both requesting -> port named by RR pointer; host_req_o=1 same cycle (combinational).
REQ-037 SHALL go IDLE->HOLD_x if host_gnt_i=0 while presenting; HOLD_x->IDLE on host_gnt_i=1; HOLD_x ignores the other port's request.
REQ-038 SHALL hold host_req_o=0 in IDLE when count==MaxOutstanding (full); HOLD is entered only when not full.
REQ-039 Host payload SHALL mux from selected port; instr selection drives we=0, be=4'hF, wdata=0, wdata_intg=0.
REQ-040 x_gnt_o SHALL equal host_gnt_i & host_req_o & (selected==x); RR pointer flips to the other port on every accepted grant.
REQ-041 SHALL push source ID into MaxOutstanding-deep FIFO on each accepted grant; pop on host_rvalid_i; simultaneous push+pop leaves count unchanged; pointers wrap modulo depth.
REQ-042 On host_rvalid_i SHALL route rdata/rdata_intg/err to FIFO head port with its rvalid=1 same cycle; other port rvalid=0; rdata/intg/err forwarded to both ports unconditionally.
REQ-043 host_rvalid_i with empty FIFO SHALL be dropped (no rvalid out) and set protocol_err_o=1 until reset.
Reset
REQ-044 While rst_i=1 at clk edge SHALL: FSM IDLE, FIFO empty (count 0), RR pointer per DataFirst, protocol_err_o=0; mid-operation, outstanding transactions are discarded.
REQ-045 host_req_o, gnt and rvalid outputs SHALL be 0 during reset cycles.
Verification
REQ-046 Both req same cycle after reset, DataFirst=1, host_gnt_i=1 -> data granted cycle 1, instr cycle 2, alternating thereafter.
REQ-047 Instr req, host_gnt_i=0 for 3 cycles, data_req rises cycle 1 -> host_addr_o stays instr_addr_i, instr_gnt_o on cycle 4, data next.
REQ-048 Two grants (instr then data) with MaxOutstanding=2, no rvalid -> host_req_o=0 third cycle; rvalid data=0x12345678 -> instr_rvalid_o, instr_rdata_o=0x12345678.
REQ-049 Grant and host_rvalid_i same cycle at count 1 -> count stays 1, response to older source.
REQ-050 host_rvalid_i with FIFO empty -> no rvalid out, protocol_err_o=1 held; rst_i pulse -> 0.
